// File: rtl/ctl_pkg.sv
// Shared definitions for the single-cycle MIPS main control unit:
// opcode and ALUop encodings plus the packed control bundle.
package ctl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Opcode register reset value. It must not be R-type (which would assert
  // RegWrite). 111111 is unassigned, so it decodes to the all-zero no-op.
  localparam logic [5:0] OP_RESET = 6'b111111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
  } ctl_t;

  localparam ctl_t CTL_NOP = '{
    reg_dst:    1'b0,
    alu_src:    1'b0,
    alu_op:     ALUOP_ADD,
    mem_to_reg: 1'b0,
    reg_write:  1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    branch:     1'b0,
    jump:       1'b0
  };

endpackage

// File: rtl/ctl_decode.sv
// Combinational opcode decoder: maps a 6-bit opcode onto the control bundle.
// Unknown opcodes produce the all-zero no-op bundle.
module ctl_decode
  import ctl_pkg::*;
(
  input  logic [5:0] op,
  output ctl_t       ctl
);

  always_comb begin
    // NOTE: default the whole bundle first so every path assigns every field;
    // this keeps the block free of inferred latches and don't-cares at 0.
    ctl = CTL_NOP;
    case (op)
      OP_RTYPE: begin
        ctl.reg_dst   = 1'b1;
        ctl.alu_op    = ALUOP_FUNCT;
        ctl.reg_write = 1'b1;
      end
      OP_LW: begin
        ctl.alu_src    = 1'b1;
        ctl.alu_op     = ALUOP_ADD;
        ctl.mem_to_reg = 1'b1;
        ctl.reg_write  = 1'b1;
        ctl.mem_read   = 1'b1;
      end
      OP_SW: begin
        ctl.alu_src   = 1'b1;
        ctl.alu_op    = ALUOP_ADD;
        ctl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctl.alu_op = ALUOP_SUB;
        ctl.branch = 1'b1;
      end
      OP_J: begin
        ctl.jump = 1'b1;
      end
      default: ctl = CTL_NOP;
    endcase
  end

endmodule

// File: rtl/ctl_top.sv
// Main control unit: registers the opcode and decodes the registered value
// into the individual datapath control signals.
module ctl_top
  import ctl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OP,
  output logic       RegDst,
  output logic       ALUsrc,
  output logic [1:0] ALUop,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       Branch,
  output logic       Jump
);

  logic [5:0] op_q;
  ctl_t       ctl;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) op_q <= OP_RESET;
    else     op_q <= OP;
  end

  ctl_decode u_decode (
    .op  (op_q),
    .ctl (ctl)
  );

  assign RegDst   = ctl.reg_dst;
  assign ALUsrc   = ctl.alu_src;
  assign ALUop    = ctl.alu_op;
  assign MemtoReg = ctl.mem_to_reg;
  assign RegWrite = ctl.reg_write;
  assign MemRead  = ctl.mem_read;
  assign MemWrite = ctl.mem_write;
  assign Branch   = ctl.branch;
  assign Jump     = ctl.jump;

endmodule

// File: tb/tb_ctl_top.sv
// Directed testbench for ctl_top: reset, decode rows, sampling, illegal
// opcodes, asynchronous reset and invariants over a random opcode sweep.
module tb_ctl_top;

  logic       clk;
  logic       clk_en;
  logic       rst;
  logic [5:0] OP;
  logic       RegDst, ALUsrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump;
  logic [1:0] ALUop;
  logic [9:0] obs;

  int checks = 0;
  int errors = 0;

  // Bundle order: RegDst, ALUsrc, ALUop[1:0], MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump
  localparam logic [9:0] EXP_ZERO = 10'b0_0_00_0_0_0_0_0_0;
  localparam logic [9:0] EXP_R    = 10'b1_0_10_0_1_0_0_0_0;
  localparam logic [9:0] EXP_LW   = 10'b0_1_00_1_1_1_0_0_0;
  localparam logic [9:0] EXP_SW   = 10'b0_1_00_0_0_0_1_0_0;
  localparam logic [9:0] EXP_BEQ  = 10'b0_0_01_0_0_0_0_1_0;
  localparam logic [9:0] EXP_J    = 10'b0_0_00_0_0_0_0_0_1;

  ctl_top dut (
    .clk      (clk),
    .rst      (rst),
    .OP       (OP),
    .RegDst   (RegDst),
    .ALUsrc   (ALUsrc),
    .ALUop    (ALUop),
    .MemtoReg (MemtoReg),
    .RegWrite (RegWrite),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Branch   (Branch),
    .Jump     (Jump)
  );

  assign obs = {RegDst, ALUsrc, ALUop, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump};

  // 160 ns period, gated so the reset test can run with no clock
  initial clk = 1'b0;
  always #80 if (clk_en) clk = ~clk;

  function automatic logic [9:0] exp_of(input logic [5:0] op);
    case (op)
      6'b000000: return EXP_R;
      6'b100011: return EXP_LW;
      6'b101011: return EXP_SW;
      6'b000100: return EXP_BEQ;
      6'b000010: return EXP_J;
      default:   return EXP_ZERO;
    endcase
  endfunction

  // Drive OP on the falling edge, then land 40 ns after the next rising edge
  task automatic step(input logic [5:0] op);
    @(negedge clk);
    OP = op;
    @(posedge clk);
    #40;
  endtask

  task automatic test_reset;
    clk_en = 1'b0;
    rst    = 1'b1;
    OP     = 6'b000000;
    #10;
    checks++;
    if (obs !== EXP_ZERO) begin
      errors++;
      $display("FAIL reset_no_clock: got %b expected %b", obs, EXP_ZERO);
    end
    rst    = 1'b0;
    clk_en = 1'b1;
    #50;
    checks++;
    if (obs !== EXP_ZERO) begin
      errors++;
      $display("FAIL reset_released_no_edge: got %b expected %b", obs, EXP_ZERO);
    end
    @(posedge clk);
    #40;
    checks++;
    if (obs !== EXP_R) begin
      errors++;
      $display("FAIL reset_first_edge_rtype: got %b expected %b", obs, EXP_R);
    end
  endtask

  task automatic test_sequence;
    logic [5:0] ops  [5] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
    logic [9:0] exps [5] = '{EXP_R, EXP_LW, EXP_SW, EXP_BEQ, EXP_J};
    for (int i = 0; i < 5; i++) begin
      step(ops[i]);
      checks++;
      if (obs !== exps[i]) begin
        errors++;
        $display("FAIL sequence[%0d] op=%b: got %b expected %b", i, ops[i], obs, exps[i]);
      end
    end
  endtask

  task automatic test_sampling;
    step(6'b100011);
    checks++;
    if (obs !== EXP_LW) begin
      errors++;
      $display("FAIL sampling_lw: got %b expected %b", obs, EXP_LW);
    end
    OP = 6'b101011;
    #20;
    checks++;
    if (obs !== EXP_LW) begin
      errors++;
      $display("FAIL sampling_hold_lw: got %b expected %b", obs, EXP_LW);
    end
    @(posedge clk);
    #40;
    checks++;
    if (obs !== EXP_SW) begin
      errors++;
      $display("FAIL sampling_switch_sw: got %b expected %b", obs, EXP_SW);
    end
  endtask

  task automatic test_illegal;
    step(6'b111111);
    checks++;
    if (obs !== EXP_ZERO) begin
      errors++;
      $display("FAIL illegal_111111: got %b expected %b", obs, EXP_ZERO);
    end
    step(6'b001000);
    checks++;
    if (obs !== EXP_ZERO) begin
      errors++;
      $display("FAIL illegal_001000: got %b expected %b", obs, EXP_ZERO);
    end
  endtask

  task automatic test_async_reset;
    step(6'b100011);
    checks++;
    if (obs !== EXP_LW) begin
      errors++;
      $display("FAIL async_pre_lw: got %b expected %b", obs, EXP_LW);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== EXP_ZERO) begin
      errors++;
      $display("FAIL async_assert_immediate: got %b expected %b", obs, EXP_ZERO);
    end
    #10;
    rst = 1'b0;
    #5;
    checks++;
    if (obs !== EXP_ZERO) begin
      errors++;
      $display("FAIL async_released_no_edge: got %b expected %b", obs, EXP_ZERO);
    end
    @(posedge clk);
    #40;
    checks++;
    if (obs !== EXP_LW) begin
      errors++;
      $display("FAIL async_recover_lw: got %b expected %b", obs, EXP_LW);
    end
  endtask

  task automatic test_invariants;
    logic [5:0] legal [5] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
    logic [5:0] op;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 1) == 0) op = legal[$urandom_range(0, 4)];
      else                           op = 6'($urandom_range(0, 63));
      step(op);
      checks++;
      if ($isunknown(obs)) begin
        errors++;
        $display("FAIL inv_no_x[%0d] op=%b: got %b expected no X/Z", i, op, obs);
      end
      checks++;
      if (RegWrite === 1'b1 && MemWrite === 1'b1) begin
        errors++;
        $display("FAIL inv_regwrite_memwrite[%0d] op=%b: got both 1 expected at most one", i, op);
      end
      checks++;
      if (Branch === 1'b1 && Jump === 1'b1) begin
        errors++;
        $display("FAIL inv_branch_jump[%0d] op=%b: got both 1 expected at most one", i, op);
      end
      checks++;
      if (obs !== exp_of(op)) begin
        errors++;
        $display("FAIL sweep_decode[%0d] op=%b: got %b expected %b", i, op, obs, exp_of(op));
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_sampling();
    test_illegal();
    test_async_reset();
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
